// File: rtl/im2col_tensor_addr_gen_pkg.sv
// rtl/im2col_tensor_addr_gen_pkg.sv - shared widths and FSM encoding for the im2col address generator
package im2col_tensor_addr_gen_pkg;
  localparam int TENSOR_W   = 8;
  localparam int KERNEL_W   = 4;
  localparam int CHANNELS_W = 8;
  localparam int STRIDE_W   = 4;
  localparam int ADDR_W     = 20;
  localparam int LANES      = 8;
  localparam int LANE_W     = $clog2(LANES);
  localparam int TMS_W      = TENSOR_W + STRIDE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/im2col_tensor_addr_gen_if.sv
// rtl/im2col_tensor_addr_gen_if.sv - address stream towards the tensor SRAM read port / S2P packer
interface im2col_tensor_addr_gen_if;
  import im2col_tensor_addr_gen_pkg::*;

  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic [LANE_W-1:0] lane;
  logic              blk_last;
  logic              patch_last;
  logic              frame_last;

  modport master (
    output addr_valid, addr, lane, blk_last, patch_last, frame_last,
    input  addr_ready
  );

  modport slave (
    input  addr_valid, addr, lane, blk_last, patch_last, frame_last,
    output addr_ready
  );
endinterface

// File: rtl/im2col_patch_walker.sv
// rtl/im2col_patch_walker.sv - c/ky/kx receptive-field walk with multiplier-free channel/row offsets
module im2col_patch_walker
  import im2col_tensor_addr_gen_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_clear,
  input  logic                  i_step,
  input  logic [KERNEL_W-1:0]   i_k,
  input  logic [CHANNELS_W-1:0] i_c,
  input  logic [TENSOR_W-1:0]   i_t,
  input  logic [ADDR_W-1:0]     i_plane,
  output logic                  o_patch_last,
  output logic [ADDR_W-1:0]     o_patch_ofs
);

  logic [CHANNELS_W-1:0] r_c;
  logic [KERNEL_W-1:0]   r_ky;
  logic [KERNEL_W-1:0]   r_kx;
  logic [ADDR_W-1:0]     r_ch_off;
  logic [ADDR_W-1:0]     r_ky_off;

  logic w_kx_end;
  logic w_ky_end;
  logic w_c_end;

  assign w_kx_end     = (r_kx == i_k - KERNEL_W'(1));
  assign w_ky_end     = (r_ky == i_k - KERNEL_W'(1));
  assign w_c_end      = (r_c == i_c - CHANNELS_W'(1));
  assign o_patch_last = w_c_end && w_ky_end && w_kx_end;
  assign o_patch_ofs  = r_ch_off + r_ky_off + ADDR_W'(r_kx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_c      <= '0;
      r_ky     <= '0;
      r_kx     <= '0;
      r_ch_off <= '0;
      r_ky_off <= '0;
    end else if (i_clear) begin
      r_c      <= '0;
      r_ky     <= '0;
      r_kx     <= '0;
      r_ch_off <= '0;
      r_ky_off <= '0;
    end else if (i_step) begin
      if (!w_kx_end) begin
        r_kx <= r_kx + KERNEL_W'(1);
      end else begin
        r_kx <= '0;
        if (!w_ky_end) begin
          r_ky     <= r_ky + KERNEL_W'(1);
          r_ky_off <= r_ky_off + ADDR_W'(i_t);
        end else begin
          r_ky     <= '0;
          r_ky_off <= '0;
          if (!w_c_end) begin
            r_c      <= r_c + CHANNELS_W'(1);
            r_ch_off <= r_ch_off + i_plane;
          end else begin
            r_c      <= '0;
            r_ch_off <= '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/im2col_tensor_addr_gen.sv
// rtl/im2col_tensor_addr_gen.sv - im2col read-address generator: FSM, oy/ox walk, handshake and S2P tags
module im2col_tensor_addr_gen
  import im2col_tensor_addr_gen_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_enable,
  input  logic [TENSOR_W-1:0]   i_tensor_size,
  input  logic [KERNEL_W-1:0]   i_kernel_size,
  input  logic [CHANNELS_W-1:0] i_channels,
  input  logic [STRIDE_W-1:0]   i_stride,
  input  logic [TENSOR_W-1:0]   i_ofs,
  input  logic [TMS_W-1:0]      i_tms,
  im2col_tensor_addr_gen_if.master addr_if,
  output logic                  o_done,
  output logic                  o_err
);

  state_t r_state;
  state_t w_state_nxt;

  logic [TENSOR_W-1:0]   r_t;
  logic [KERNEL_W-1:0]   r_k;
  logic [CHANNELS_W-1:0] r_c;
  logic [STRIDE_W-1:0]   r_s;
  logic [TENSOR_W-1:0]   r_ofs;
  logic [TMS_W-1:0]      r_tms;
  logic [ADDR_W-1:0]     r_plane;

  logic [TENSOR_W-1:0] r_oy;
  logic [TENSOR_W-1:0] r_ox;
  logic [ADDR_W-1:0]   r_row_base;
  logic [ADDR_W-1:0]   r_col_base;
  logic [LANE_W-1:0]   r_lane;
  logic                r_valid;
  logic                r_done;
  logic                r_err;

  logic [2*TENSOR_W-1:0] w_plane_full;
  logic                  w_cfg_err;
  logic                  w_xfer;
  logic                  w_clear;
  logic                  w_patch_last;
  logic                  w_frame_last;
  logic [ADDR_W-1:0]     w_patch_ofs;

  assign w_plane_full = {{TENSOR_W{1'b0}}, i_tensor_size} * {{TENSOR_W{1'b0}}, i_tensor_size};
  assign w_cfg_err    = (i_kernel_size == '0) || (i_stride == '0) || (i_channels == '0) ||
                        (TENSOR_W'(i_kernel_size) > i_tensor_size);
  assign w_xfer       = r_valid && addr_if.addr_ready;
  assign w_clear      = !i_enable || (r_state != ST_RUN);
  assign w_frame_last = w_patch_last && (r_oy == r_ofs) && (r_ox == r_ofs);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_INIT;
        ST_INIT: w_state_nxt = w_cfg_err ? ST_DONE : ST_RUN;
        ST_RUN:  w_state_nxt = (w_xfer && w_frame_last) ? ST_DONE : ST_RUN;
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with the state change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      r_err   <= (w_state_nxt == ST_DONE) && ((r_state == ST_INIT) ? w_cfg_err : r_err);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_t     <= '0;
      r_k     <= '0;
      r_c     <= '0;
      r_s     <= '0;
      r_ofs   <= '0;
      r_tms   <= '0;
      r_plane <= '0;
    end else if (r_state == ST_INIT) begin
      r_t     <= i_tensor_size;
      r_k     <= i_kernel_size;
      r_c     <= i_channels;
      r_s     <= i_stride;
      r_ofs   <= i_ofs;
      r_tms   <= i_tms;
      r_plane <= ADDR_W'(w_plane_full);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_oy       <= '0;
      r_ox       <= '0;
      r_row_base <= '0;
      r_col_base <= '0;
      r_lane     <= '0;
    end else if (w_clear) begin
      r_oy       <= '0;
      r_ox       <= '0;
      r_row_base <= '0;
      r_col_base <= '0;
      r_lane     <= '0;
    end else if (w_xfer) begin
      r_lane <= w_patch_last ? '0 : r_lane + LANE_W'(1);
      if (w_patch_last) begin
        if (r_ox == r_ofs) begin
          r_ox       <= '0;
          r_col_base <= '0;
          r_oy       <= r_oy + TENSOR_W'(1);
          r_row_base <= r_row_base + ADDR_W'(r_tms);
        end else begin
          r_ox       <= r_ox + TENSOR_W'(1);
          r_col_base <= r_col_base + ADDR_W'(r_s);
        end
      end
    end
  end

  im2col_patch_walker u_walker (
    .clk          (clk),
    .rstn         (rstn),
    .i_clear      (w_clear),
    .i_step       (w_xfer),
    .i_k          (r_k),
    .i_c          (r_c),
    .i_t          (r_t),
    .i_plane      (r_plane),
    .o_patch_last (w_patch_last),
    .o_patch_ofs  (w_patch_ofs)
  );

  assign addr_if.addr_valid = r_valid;
  assign addr_if.addr       = r_valid ? (r_row_base + r_col_base + w_patch_ofs) : '0;
  assign addr_if.lane       = r_valid ? r_lane : '0;
  assign addr_if.patch_last = r_valid && w_patch_last;
  assign addr_if.blk_last   = r_valid && (w_patch_last || (r_lane == LANE_W'(LANES - 1)));
  assign addr_if.frame_last = r_valid && w_frame_last;
  assign o_done             = r_done;
  assign o_err              = r_err;

endmodule

// File: tb/tb_im2col_tensor_addr_gen.sv
// tb/tb_im2col_tensor_addr_gen.sv - randomized bench for im2col_tensor_addr_gen against a loop-level model
module tb_im2col_tensor_addr_gen;
  import im2col_tensor_addr_gen_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                lane;
    bit                bl;
    bit                pl;
    bit                fl;
  } exp_t;

  logic                  clk;
  logic                  rstn;
  logic                  i_enable;
  logic [TENSOR_W-1:0]   i_tensor_size;
  logic [KERNEL_W-1:0]   i_kernel_size;
  logic [CHANNELS_W-1:0] i_channels;
  logic [STRIDE_W-1:0]   i_stride;
  logic [TENSOR_W-1:0]   i_ofs;
  logic [TMS_W-1:0]      i_tms;
  logic                  o_done;
  logic                  o_err;

  im2col_tensor_addr_gen_if u_if ();

  im2col_tensor_addr_gen dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_enable      (i_enable),
    .i_tensor_size (i_tensor_size),
    .i_kernel_size (i_kernel_size),
    .i_channels    (i_channels),
    .i_stride      (i_stride),
    .i_ofs         (i_ofs),
    .i_tms         (i_tms),
    .addr_if       (u_if),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk;
  int   n_fail;
  exp_t exp_q[$];
  int   got_q[$];

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  function automatic int got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return -1;
  endfunction

  // Reference: im2col order with addresses from direct multiplication, lane = index within patch mod LANES.
  function automatic void build(input int t, input int k, input int c, input int s, input int ofs);
    exp_t e;
    int   idx;
    exp_q.delete();
    for (int oy = 0; oy <= ofs; oy++)
      for (int ox = 0; ox <= ofs; ox++) begin
        idx = 0;
        for (int ch = 0; ch < c; ch++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              e.addr = ADDR_W'(oy * s * t + ox * s + ch * t * t + ky * t + kx);
              e.lane = idx % LANES;
              e.pl   = (ch == c - 1) && (ky == k - 1) && (kx == k - 1);
              e.bl   = (e.lane == LANES - 1) || e.pl;
              e.fl   = e.pl && (oy == ofs) && (ox == ofs);
              exp_q.push_back(e);
              idx++;
            end
      end
  endfunction

  task automatic set_cfg(input int t, input int k, input int c, input int s, input int ofs);
    i_tensor_size = TENSOR_W'(t);
    i_kernel_size = KERNEL_W'(k);
    i_channels    = CHANNELS_W'(c);
    i_stride      = STRIDE_W'(s);
    i_ofs         = TENSOR_W'(ofs);
    i_tms         = TMS_W'(t * s);
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low 3 cycles after the 5th transfer
  task automatic run_frame(input int t, input int k, input int c, input int s, input int ofs,
                           input int mode, input int abort_at, output int ntr);
    int cyc;
    int stall;
    int total;
    bit first;
    bit rdy;
    set_cfg(t, k, c, s, ofs);
    build(t, k, c, s, ofs);
    total = exp_q.size();
    got_q.delete();
    ntr   = 0;
    cyc   = 0;
    stall = 0;
    first = 1'b1;
    u_if.addr_ready = 1'b0;
    @(negedge clk);
    i_enable = 1'b1;
    @(negedge clk);
    chk("init_no_valid", u_if.addr_valid, 0);
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 5000) begin
        chk("frame_timeout", 0, 1);
        break;
      end
      if (u_if.addr_valid) begin
        if (first) chk("first_valid_latency", cyc, 1);
        first = 1'b0;
        if (exp_q.size() == 0) begin
          chk("extra_addr", 1, 0);
          break;
        end
        chk("addr", u_if.addr, exp_q[0].addr);
        chk("lane", u_if.lane, exp_q[0].lane);
        chk("blk_last", u_if.blk_last, exp_q[0].bl);
        chk("patch_last", u_if.patch_last, exp_q[0].pl);
        chk("frame_last", u_if.frame_last, exp_q[0].fl);
        if (mode == 2 && ntr == 5) chk("stall_hold_addr", u_if.addr, 2);
        case (mode)
          1:       rdy = ($urandom_range(0, 1) == 1);
          2:       rdy = !(ntr == 5 && stall < 3);
          default: rdy = 1'b1;
        endcase
        if (!rdy) stall++;
        u_if.addr_ready = rdy;
        if (rdy) begin
          got_q.push_back(int'(u_if.addr));
          void'(exp_q.pop_front());
          ntr++;
          if (ntr == abort_at) begin
            i_enable = 1'b0;
            @(negedge clk);
            u_if.addr_ready = 1'b0;
            chk("abort_valid", u_if.addr_valid, 0);
            chk("abort_done", o_done, 0);
            return;
          end
        end
      end else if (o_done) begin
        break;
      end else begin
        chk("valid_dropped_midframe", 0, 1);
        break;
      end
    end
    u_if.addr_ready = 1'b0;
    chk("frame_count", ntr, total);
    chk("exp_drained", exp_q.size(), 0);
    chk("done_set", o_done, 1);
    chk("err_clear", o_err, 0);
    @(negedge clk);
    chk("done_held", o_done, 1);
    chk("valid_after_done", u_if.addr_valid, 0);
    i_enable = 1'b0;
    @(negedge clk);
    chk("done_cleared", o_done, 0);
  endtask

  task automatic err_case(input int t, input int k, input int c, input int s);
    set_cfg(t, k, c, s, 1);
    @(negedge clk);
    i_enable = 1'b1;
    @(negedge clk);
    chk("err_edge1_done", o_done, 0);
    @(negedge clk);
    chk("err_flag", o_err, 1);
    chk("err_done", o_done, 1);
    chk("err_no_valid", u_if.addr_valid, 0);
    repeat (3) begin
      @(negedge clk);
      chk("err_hold_no_valid", u_if.addr_valid, 0);
      chk("err_hold_flag", o_err, 1);
    end
    i_enable = 1'b0;
    @(negedge clk);
    chk("err_release_err", o_err, 0);
    chk("err_release_done", o_done, 0);
  endtask

  int lit1[12] = '{0, 1, 4, 5, 1, 2, 5, 6, 10, 11, 14, 15};
  int lit2[8]  = '{0, 1, 3, 4, 9, 10, 12, 13};
  int lit3[9]  = '{2, 3, 4, 7, 8, 9, 12, 13, 14};

  initial begin
    int n;
    int t, k, c, s, ofs;
    n_chk  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    i_enable = 1'b0;
    u_if.addr_ready = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_valid", u_if.addr_valid, 0);
    chk("rst_addr", u_if.addr, 0);
    chk("rst_lane", u_if.lane, 0);
    chk("rst_blk_last", u_if.blk_last, 0);
    chk("rst_patch_last", u_if.patch_last, 0);
    chk("rst_frame_last", u_if.frame_last, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    rstn = 1'b1;

    run_frame(4, 2, 1, 1, 2, 0, -1, n);
    chk("case1_total", n, 36);
    for (int i = 0; i < 8; i++) chk("case1_patch01", got_at(i), lit1[i]);
    for (int i = 0; i < 4; i++) chk("case1_last_patch", got_at(32 + i), lit1[8 + i]);

    run_frame(3, 2, 2, 1, 1, 0, -1, n);
    for (int i = 0; i < 8; i++) chk("case2_patch0", got_at(i), lit2[i]);

    run_frame(5, 3, 1, 2, 1, 0, -1, n);
    for (int i = 0; i < 9; i++) chk("case3_ox1_patch", got_at(9 + i), lit3[i]);
    chk("case3_oy1_start", got_at(18), 10);

    run_frame(4, 2, 1, 1, 2, 2, -1, n);
    chk("stall_total", n, 36);
    chk("stall_no_skip", got_at(5), 2);

    run_frame(4, 2, 1, 1, 2, 0, 10, n);
    chk("abort_count", n, 10);
    run_frame(4, 2, 1, 1, 2, 0, -1, n);
    chk("restart_total", n, 36);
    chk("restart_first", got_at(0), 0);

    err_case(4, 5, 1, 1);
    err_case(4, 2, 1, 0);
    err_case(4, 2, 0, 1);
    err_case(4, 0, 1, 1);

    for (int r = 0; r < 8; r++) begin
      t   = $urandom_range(1, 8);
      k   = $urandom_range(1, (t < 4) ? t : 4);
      c   = $urandom_range(1, 3);
      s   = $urandom_range(1, 3);
      ofs = $urandom_range(0, 2);
      run_frame(t, k, c, s, ofs, 1, -1, n);
      chk("rand_total", n, (ofs + 1) * (ofs + 1) * k * k * c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
